conv_after_pool_cu: RTL and testbench



---
 rtl/conv_after_pool_cu_pkg.sv | 30 +++
 rtl/delay_3_1.sv | 26 ++
 rtl/conv_after_pool_cu.sv | 198 +++++++++++++++++++
 tb/tb_conv_after_pool_cu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/conv_after_pool_cu_pkg.sv
// Shared types and size helpers for the post-pooling convolution control units.
// Sibling control units reuse the FSM encodings and the derived-size functions.
package conv_after_pool_cu_pkg;

  typedef enum logic [1:0] {IDLE, READ, HOLD} main_state_e;
  typedef enum logic {EMPTY, FULL} hand_state_e;

  // Read-cycle strobes carried to the MAC; wr marks the final tap of the last group.
  typedef struct packed {
    logic en;
    logic first;
    logic last;
    logic clear;
    logic wr;
  } mac_strobe_t;

  function automatic int calc_groups(input int depth, input int units);
    return (depth + units - 1) / units;
  endfunction

  function automatic int calc_ofm(input int ifm, input int k);
    return ifm - k + 1;
  endfunction

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_3_1.sv
// Fixed-latency register pipeline with synchronous active-low clear.
// Keeps strobes aligned with the memory read latency.
module delay_3_1 #(
  parameter int WIDTH        = 1,
  parameter int delay_cycles = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [delay_cycles-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < delay_cycles; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[delay_cycles-1];

endmodule

// File: rtl/conv_after_pool_cu.sv
// Control unit for the K x K stride-1 convolution fed by the pooling stage.
// Walks windows per depth group, drives MAC strobes, and hands finished maps downstream.
module conv_after_pool_cu
  import conv_after_pool_cu_pkg::*;
#(
  parameter int IFM_SIZE            = 3,
  parameter int IFM_DEPTH           = 16,
  parameter int KERNAL_SIZE         = 2,
  parameter int NUMBER_OF_UNITS     = 3,
  parameter int GROUPS              = calc_groups(IFM_DEPTH, NUMBER_OF_UNITS),
  parameter int OFM_SIZE            = calc_ofm(IFM_SIZE, KERNAL_SIZE),
  parameter int ADDRESS_SIZE_IFM    = $clog2(IFM_SIZE*IFM_SIZE),
  parameter int ADDRESS_SIZE_OFM    = $clog2(OFM_SIZE*OFM_SIZE),
  parameter int ADDRESS_SIZE_WEIGHT = $clog2(GROUPS*KERNAL_SIZE*KERNAL_SIZE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_from_previous,
  output logic                           end_to_previous,
  output logic                           ifm_enable_read_current,
  output logic [ADDRESS_SIZE_IFM-1:0]    ifm_address_read_current,
  output logic [$clog2(GROUPS)-1:0]      ifm_sel_current,
  output logic [ADDRESS_SIZE_WEIGHT-1:0] weight_address,
  output logic                           mac_enable,
  output logic                           mac_first,
  output logic                           mac_last,
  output logic [ADDRESS_SIZE_OFM-1:0]    psum_address,
  output logic                           psum_clear,
  output logic                           ofm_enable_write_next,
  output logic [ADDRESS_SIZE_OFM-1:0]    ofm_address_write_next,
  output logic                           start_to_next,
  input  logic                           end_from_next
);

  localparam int OW = cnt_w(OFM_SIZE);
  localparam int KW = cnt_w(KERNAL_SIZE);
  localparam int GW = $clog2(GROUPS);
  localparam int AI = ADDRESS_SIZE_IFM;
  localparam int AO = ADDRESS_SIZE_OFM;
  localparam int AW = ADDRESS_SIZE_WEIGHT;
  localparam int SW = $bits(mac_strobe_t);

  localparam logic [OW-1:0] O_MAX    = OW'(OFM_SIZE-1);
  localparam logic [KW-1:0] K_MAX    = KW'(KERNAL_SIZE-1);
  localparam logic [GW-1:0] G_MAX    = GW'(GROUPS-1);
  localparam logic [AI-1:0] IFM_A    = AI'(IFM_SIZE);
  localparam logic [AO-1:0] OFM_A    = AO'(OFM_SIZE);
  localparam logic [AO-1:0] OFM_LAST = AO'(OFM_SIZE*OFM_SIZE-1);
  localparam logic [AW-1:0] K_A      = AW'(KERNAL_SIZE);
  localparam logic [AW-1:0] KK_A     = AW'(KERNAL_SIZE*KERNAL_SIZE);

  main_state_e state, state_n;
  hand_state_e hstate, hstate_n;

  logic [OW-1:0] orow, ocol;
  logic [KW-1:0] kr, kc;
  logic [GW-1:0] ifm_sel;
  logic [AO-1:0] wr_addr;
  logic          pending;
  logic          mem_full;
  logic          rd_en;
  logic          kc_last, kr_last, ocol_last, orow_last, tap_final;

  assign kc_last   = (kc == K_MAX);
  assign kr_last   = (kr == K_MAX);
  assign ocol_last = (ocol == O_MAX);
  assign orow_last = (orow == O_MAX);
  assign tap_final = kc_last && kr_last && ocol_last && orow_last;
  assign mem_full  = (hstate == FULL);
  assign rd_en     = (state == READ);

  // Main sequencing FSM
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start_from_previous || pending)
              state_n = (ifm_sel == G_MAX && mem_full) ? HOLD : READ;
      READ: if (tap_final) state_n = IDLE;
      HOLD: if (!mem_full) state_n = READ;
      default: state_n = IDLE;
    endcase
  end

  // A start that lands while busy is remembered once; a second one is dropped.
  always_ff @(posedge clk) begin
    if (!reset)
      pending <= 1'b0;
    else if (state == IDLE && (start_from_previous || pending))
      pending <= 1'b0;
    else if (state != IDLE && start_from_previous)
      pending <= 1'b1;
  end

  // Window/tap counters, nested orow > ocol > kr > kc; all wrap to 0 after the final tap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      orow    <= '0;
      ocol    <= '0;
      kr      <= '0;
      kc      <= '0;
      ifm_sel <= '0;
    end else if (rd_en) begin
      if (kc_last) begin
        kc <= '0;
        if (kr_last) begin
          kr <= '0;
          if (ocol_last) begin
            ocol <= '0;
            orow <= orow_last ? '0 : orow + 1'b1;
          end else begin
            ocol <= ocol + 1'b1;
          end
        end else begin
          kr <= kr + 1'b1;
        end
      end else begin
        kc <= kc + 1'b1;
      end
      if (tap_final) ifm_sel <= (ifm_sel == G_MAX) ? '0 : ifm_sel + 1'b1;
    end
  end

  assign end_to_previous          = (state == IDLE);
  assign ifm_enable_read_current  = rd_en;
  assign ifm_sel_current          = ifm_sel;
  assign ifm_address_read_current = (AI'(orow) + AI'(kr)) * IFM_A + AI'(ocol) + AI'(kc);
  assign weight_address           = AW'(ifm_sel) * KK_A + AW'(kr) * K_A + AW'(kc);

  // Read-cycle strobes, delayed one cycle to line up with the memory data.
  mac_strobe_t   strb_rd, strb_mac;
  logic [AO-1:0] psum_rd;
  logic [SW+AO-1:0] mac_d, mac_q;

  always_comb begin
    strb_rd       = '0;
    strb_rd.en    = rd_en;
    strb_rd.first = rd_en && (kr == '0) && (kc == '0);
    strb_rd.last  = rd_en && kr_last && kc_last;
    strb_rd.clear = rd_en && (ifm_sel == '0);
    strb_rd.wr    = rd_en && kr_last && kc_last && (ifm_sel == G_MAX);
  end

  assign psum_rd = AO'(orow) * OFM_A + AO'(ocol);
  assign mac_d   = {strb_rd, psum_rd};

  delay_3_1 #(.WIDTH(SW+AO), .delay_cycles(1)) u_mac_dly (
    .clk   (clk),
    .reset (reset),
    .d     (mac_d),
    .q     (mac_q)
  );

  assign {strb_mac, psum_address} = mac_q;
  assign mac_enable = strb_mac.en;
  assign mac_first  = strb_mac.first;
  assign mac_last   = strb_mac.last;
  assign psum_clear = strb_mac.clear;

  // Finished sums leave the MAC one cycle after the last tap of a last-group window.
  delay_3_1 #(.WIDTH(1), .delay_cycles(1)) u_wr_dly (
    .clk   (clk),
    .reset (reset),
    .d     (strb_mac.wr),
    .q     (ofm_enable_write_next)
  );

  always_ff @(posedge clk) begin
    if (!reset)
      wr_addr <= '0;
    else if (ofm_enable_write_next)
      wr_addr <= (wr_addr == OFM_LAST) ? '0 : wr_addr + 1'b1;
  end

  assign ofm_address_write_next = wr_addr;

  // Hand-off FSM for the next-layer memory
  always_ff @(posedge clk) begin
    if (!reset) hstate <= EMPTY;
    else        hstate <= hstate_n;
  end

  always_comb begin
    hstate_n = hstate;
    case (hstate)
      EMPTY: if (ofm_enable_write_next && wr_addr == OFM_LAST) hstate_n = FULL;
      FULL:  if (end_from_next) hstate_n = EMPTY;
      default: hstate_n = EMPTY;
    endcase
  end

  assign start_to_next = mem_full && end_from_next;

endmodule

// File: tb/tb_conv_after_pool_cu.sv
// Directed bench for conv_after_pool_cu: reset, group sweeps, back-pressure, pending start, mid-read reset.
module tb_conv_after_pool_cu;
  import conv_after_pool_cu_pkg::*;

  localparam int NG = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_from_previous = 1'b0;
  logic       end_from_next = 1'b0;
  logic       end_to_previous;
  logic       ifm_enable_read_current;
  logic [3:0] ifm_address_read_current;
  logic [2:0] ifm_sel_current;
  logic [4:0] weight_address;
  logic       mac_enable, mac_first, mac_last, psum_clear;
  logic [1:0] psum_address;
  logic       ofm_enable_write_next;
  logic [1:0] ofm_address_write_next;
  logic       start_to_next;

  conv_after_pool_cu dut (
    .clk                      (clk),
    .reset                    (reset),
    .start_from_previous      (start_from_previous),
    .end_to_previous          (end_to_previous),
    .ifm_enable_read_current  (ifm_enable_read_current),
    .ifm_address_read_current (ifm_address_read_current),
    .ifm_sel_current          (ifm_sel_current),
    .weight_address           (weight_address),
    .mac_enable               (mac_enable),
    .mac_first                (mac_first),
    .mac_last                 (mac_last),
    .psum_address             (psum_address),
    .psum_clear               (psum_clear),
    .ofm_enable_write_next    (ofm_enable_write_next),
    .ofm_address_write_next   (ofm_address_write_next),
    .start_to_next            (start_to_next),
    .end_from_next            (end_from_next)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int exp_addr [16] = '{0,1,3,4, 1,2,4,5, 3,4,6,7, 4,5,7,8};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Caller raises start (or arranges pending/HOLD release) so the next cycle is read 1.
  task automatic run_group(input int g, input int pend_at, input logic nxt);
    int t;
    logic wr;
    for (int j = 1; j <= 18; j++) begin
      tick();
      start_from_previous = 1'b0;
      if (pend_at != 0 && j == pend_at + 1) check("pending_set", dut.pending, 1);
      if (j <= 16) begin
        check("rd_en", ifm_enable_read_current, 1);
        check("rd_addr", ifm_address_read_current, exp_addr[j-1]);
        check("w_addr", weight_address, g*4 + (j-1)%4);
        check("sel", ifm_sel_current, g);
        check("end_prev_busy", end_to_previous, 0);
      end else if (j == 17) begin
        check("rd_en_done", ifm_enable_read_current, 0);
        check("end_prev_done", end_to_previous, 1);
        check("sel_next", ifm_sel_current, (g+1)%NG);
      end else begin
        check("rd_en_after", ifm_enable_read_current, nxt);
      end
      check("mac_en", mac_enable, (j >= 2 && j <= 17));
      if (j >= 2 && j <= 17) begin
        t = j - 2;
        check("mac_first", mac_first, (t%4 == 0));
        check("mac_last", mac_last, (t%4 == 3));
        check("psum_addr", psum_address, t/4);
        check("psum_clear", psum_clear, (g == 0));
      end
      wr = (g == NG-1) && (j >= 6) && ((j-6)%4 == 0);
      check("ofm_wr", ofm_enable_write_next, wr);
      if (wr) check("ofm_addr", ofm_address_write_next, (j-6)/4);
      if (j == pend_at) start_from_previous = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b0;
    tick(); tick();
    check("rst_end_prev", end_to_previous, 1);
    check("rst_rd_en", ifm_enable_read_current, 0);
    check("rst_rd_addr", ifm_address_read_current, 0);
    check("rst_sel", ifm_sel_current, 0);
    check("rst_w_addr", weight_address, 0);
    check("rst_mac_en", mac_enable, 0);
    check("rst_mac_first", mac_first, 0);
    check("rst_mac_last", mac_last, 0);
    check("rst_psum", psum_address, 0);
    check("rst_clear", psum_clear, 0);
    check("rst_ofm_wr", ofm_enable_write_next, 0);
    check("rst_ofm_addr", ofm_address_write_next, 0);
    check("rst_stn", start_to_next, 0);
    reset = 1'b1;
    tick();
    check("idle_rd_en", ifm_enable_read_current, 0);

    // Single group followed by the rest of a full sweep
    for (int g = 0; g < NG; g++) begin
      start_from_previous = 1'b1;
      run_group(g, 0, 1'b0);
    end
    check("full_before", dut.mem_full, 0);
    tick();
    check("full_after_sweep", dut.mem_full, 1);
    check("sel_wrapped", ifm_sel_current, 0);

    // Back-pressure: downstream still busy across a second sweep
    for (int g = 0; g < NG-1; g++) begin
      start_from_previous = 1'b1;
      run_group(g, 0, 1'b0);
    end
    check("full_held", dut.mem_full, 1);
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    check("hold_end_prev", end_to_previous, 0);
    check("hold_rd_en", ifm_enable_read_current, 0);
    check("hold_sel", ifm_sel_current, NG-1);
    tick(); tick();
    check("hold_end_prev2", end_to_previous, 0);
    check("hold_rd_en2", ifm_enable_read_current, 0);
    end_from_next = 1'b1;
    #1;
    check("stn_pulse", start_to_next, 1);
    tick();
    end_from_next = 1'b0;
    #1;
    check("stn_low", start_to_next, 0);
    check("full_released", dut.mem_full, 0);
    check("hold_rd_en3", ifm_enable_read_current, 0);
    run_group(NG-1, 0, 1'b0);
    tick();
    check("full_again", dut.mem_full, 1);
    end_from_next = 1'b1;
    #1;
    check("stn_pulse2", start_to_next, 1);
    tick();
    end_from_next = 1'b0;
    check("full_released2", dut.mem_full, 0);

    // Pending start at read cycle 5 launches the next group at cycle 18
    start_from_previous = 1'b1;
    run_group(0, 5, 1'b1);
    check("pend_rd_addr", ifm_address_read_current, 0);
    check("pend_w_addr", weight_address, 4);
    check("pend_sel", ifm_sel_current, 1);
    check("pend_cleared", dut.pending, 0);

    // Reset at read cycle 8
    repeat (7) tick();
    check("mid_rd_en", ifm_enable_read_current, 1);
    check("mid_rd_addr", ifm_address_read_current, exp_addr[7]);
    reset = 1'b0;
    tick();
    check("mrst_end_prev", end_to_previous, 1);
    check("mrst_rd_en", ifm_enable_read_current, 0);
    check("mrst_rd_addr", ifm_address_read_current, 0);
    check("mrst_w_addr", weight_address, 0);
    check("mrst_sel", ifm_sel_current, 0);
    check("mrst_mac_en", mac_enable, 0);
    check("mrst_pending", dut.pending, 0);
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
